inst_loader: RTL and testbench
==============================

// Module: inst_loader
// PURPOSE
//   Byte-stream program loader that drives the instruction-memory write port (inst_wen/inst_addr/inst_data).
//   Accepts a framed byte stream (from a UART RX or testbench), packs little-endian 32-bit words and writes
//   them to consecutive word addresses from 0. Holds the CPU stalled (cpu_hold) while loading.
// PARAMETERS
//   ADDR_W  7    word-address width of instruction memory
//   DEPTH   128  number of instruction words; max legal frame length
//   DATA_W  32   instruction word width (fixed 32; 4 bytes per word)
// PORTS
//   clk        in   1       clock
//   rst        in   1       reset, synchronous, active-high
//   start      in   1       1-cycle pulse; begins a load frame (ignored while busy)
//   in_valid   in   1       byte-stream valid
//   in_byte    in   8       byte-stream data
//   in_ready   out  1       byte accepted when in_valid && in_ready
//   inst_wen   out  1       instruction-memory write enable (1-cycle pulse per word)
//   inst_addr  out  ADDR_W  instruction-memory word address
//   inst_data  out  32      instruction word
//   busy       out  1       frame in progress
//   cpu_hold   out  1       stall/reset request to core; equals busy
//   done       out  1       level; frame completed OK (sticky until next start)
//   err        out  1       level; frame rejected (sticky until next start)
// BEHAVIOUR
// - Reset: rst is synchronous, active-high; clock is clk. All outputs 0; state IDLE; counters and checksum cleared.
//   Reset mid-frame aborts immediately; already-written words stay in memory.
// - Frame: LEN_LO, LEN_HI (N = 16-bit word count, LE), then 4*N data bytes, LE per word
//   (byte0 -> inst_data[7:0] ... byte3 -> inst_data[31:24]).
// - FSM: IDLE -start-> LEN_LO -byte-> LEN_HI -byte-> {N==0: DONE | N>DEPTH: ERR | else DATA}
//   DATA -(last byte of word N-1 accepted)-> FLUSH -(write issued)-> DONE.
//   DONE/ERR -start-> LEN_LO (clears done/err same edge). start in LEN_*/DATA/FLUSH ignored.
// - in_ready = 1 in LEN_LO, LEN_HI, DATA (and CSUM when enabled); 0 in IDLE, FLUSH, DONE, ERR.
// - Byte counter: 2 bits, wraps 3->0 on each accepted data byte. Word counter: ADDR_W+1 bits.
// - Write: on acceptance of byte3, the next cycle has inst_wen=1 with inst_addr=word index,
//   inst_data=packed word; both are stable for that cycle. Next-word bytes may be accepted during the write cycle.
// - inst_addr increments after each write; the final write goes to N-1. Address never wraps, because N<=DEPTH is enforced.
// - busy=1 from the edge after start through the last write cycle; done/err rise the cycle after.
// - N==DEPTH is legal (fills 0..DEPTH-1). N==DEPTH+1 -> ERR with no writes.
// - in_valid while in_ready=0: byte is not consumed; the source holds it.
// CONFIGURATION
//   INST_LOADER_CSUM_EN defined: after the data bytes, one extra byte (state CSUM) = 8-bit sum mod 256 of all
//   data bytes. Match -> DONE; mismatch -> ERR (words already written, err=1). The sum excludes the length bytes.
//   Undefined: no CSUM state; DATA -> FLUSH -> DONE directly; the sum logic is absent.
// STRUCTURE
// - Shared package rv32i_pkg: loader state encoding localparams (IDLE, LEN_LO, LEN_HI, DATA, CSUM, FLUSH,
//   DONE, ERR), IMEM_ADDR_W=7, IMEM_DEPTH=128.
// - Sub-module byte_packer: 2-bit lane counter + 32-bit shift/assemble register.
//   Outputs word_valid pulse and word; clear input driven by the FSM on start.
// - Top: FSM, length register, word counter, write-port register stage, optional checksum.
// TESTING
// 1. rst mid-DATA (after 5 bytes): outputs return to 0 in the next cycle; a new start then loads a 1-word frame correctly.
// 2. start; bytes 01 00 13 00 00 00 -> one inst_wen, addr 0, data 0x00000013;
//    done=1, busy=0; in_valid gaps are tolerated.
// 3. start; N=0x0080 + 512 bytes -> 128 writes, addr 0..127; done; no write to any address >=128.
// 4. start; N=0x0081 -> err=1, zero inst_wen pulses, in_ready=0 afterward.
// 5. N=0 -> done one cycle after LEN_HI, no writes; start while busy leaves state unchanged.
// 6. CSUM_EN: 1 word 0x00000013 + csum 0x13 -> done; csum 0x14 -> err=1 with word 0 written.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared core definitions used by the instruction loader: imem geometry and
// loader state encoding.
package rv32i_pkg;

    localparam int IMEM_ADDR_W = 7;
    localparam int IMEM_DEPTH  = 128;

    localparam logic [2:0] LD_IDLE   = 3'd0;
    localparam logic [2:0] LD_LEN_LO = 3'd1;
    localparam logic [2:0] LD_LEN_HI = 3'd2;
    localparam logic [2:0] LD_DATA   = 3'd3;
    localparam logic [2:0] LD_CSUM   = 3'd4;
    localparam logic [2:0] LD_FLUSH  = 3'd5;
    localparam logic [2:0] LD_DONE   = 3'd6;
    localparam logic [2:0] LD_ERR    = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE   = LD_IDLE,
        S_LEN_LO = LD_LEN_LO,
        S_LEN_HI = LD_LEN_HI,
        S_DATA   = LD_DATA,
        S_CSUM   = LD_CSUM,
        S_FLUSH  = LD_FLUSH,
        S_DONE   = LD_DONE,
        S_ERR    = LD_ERR
    } ld_state_e;

endpackage

// File: rtl/inst_loader_if.sv
// Loader control, byte-stream and instruction-memory write-port bundle.
// master = host/byte source + memory side, slave = the loader itself.
interface inst_loader_if #(
    parameter int ADDR_W = rv32i_pkg::IMEM_ADDR_W
);
    logic              start;
    logic              in_valid;
    logic [7:0]        in_byte;
    logic              in_ready;
    logic              inst_wen;
    logic [ADDR_W-1:0] inst_addr;
    logic [31:0]       inst_data;
    logic              busy;
    logic              cpu_hold;
    logic              done;
    logic              err;

    modport master (
        output start, in_valid, in_byte,
        input  in_ready, inst_wen, inst_addr, inst_data, busy, cpu_hold, done, err
    );

    modport slave (
        input  start, in_valid, in_byte,
        output in_ready, inst_wen, inst_addr, inst_data, busy, cpu_hold, done, err
    );
endinterface

// File: rtl/inst_loader_byte_packer.sv
// Assembles four little-endian bytes into a 32-bit word; word_valid pulses
// combinationally with the fourth byte so the caller can register it.
module byte_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        accept,
    input  logic [7:0]  in_byte,
    output logic        word_valid,
    output logic [31:0] word
);
    logic [1:0]  lane;
    logic [23:0] low;

    assign word_valid = accept && (lane == 2'd3);
    assign word       = {in_byte, low};

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            lane <= 2'd0;
            low  <= '0;
        end else if (accept) begin
            case (lane)
                2'd0:    low[7:0]   <= in_byte;
                2'd1:    low[15:8]  <= in_byte;
                2'd2:    low[23:16] <= in_byte;
                default: ;
            endcase
            lane <= lane + 2'd1;
        end
    end
endmodule

// File: rtl/inst_loader.sv
// Framed byte-stream program loader writing consecutive imem words from 0.
// Define INST_LOADER_CSUM_EN to require a trailing 8-bit sum byte per frame.
module inst_loader
    import rv32i_pkg::*;
#(
    parameter int ADDR_W = IMEM_ADDR_W,
    parameter int DEPTH  = IMEM_DEPTH,
    parameter int DATA_W = 32
) (
    input logic         clk,
    input logic         rst,
    inst_loader_if.slave bus
);
    ld_state_e         state;
    logic [7:0]        len_lo;
    logic [15:0]       len;
    logic [ADDR_W:0]   word_cnt;
    logic              busy, done, err;
    logic              inst_wen;
    logic [ADDR_W-1:0] inst_addr;
    logic [DATA_W-1:0] inst_data;
`ifdef INST_LOADER_CSUM_EN
    logic [7:0]        csum;
`endif

    logic        in_ready, accept, start_ok, data_accept, word_valid, last_word;
    logic [15:0] len_next;
    logic [31:0] word;

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        in_ready = 1'b0;
        case (state)
            S_LEN_LO, S_LEN_HI, S_DATA: in_ready = 1'b1;
`ifdef INST_LOADER_CSUM_EN
            S_CSUM:                     in_ready = 1'b1;
`endif
            default: ;
        endcase
    end

    assign accept      = bus.in_valid && in_ready;
    assign start_ok    = bus.start && (state == S_IDLE || state == S_DONE || state == S_ERR);
    assign data_accept = accept && (state == S_DATA);
    assign len_next    = {bus.in_byte, len_lo};
    assign last_word   = (16'(word_cnt) == len - 16'd1);

    byte_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (start_ok),
        .accept     (data_accept),
        .in_byte    (bus.in_byte),
        .word_valid (word_valid),
        .word       (word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            len_lo    <= '0;
            len       <= '0;
            word_cnt  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            inst_wen  <= 1'b0;
            inst_addr <= '0;
            inst_data <= '0;
`ifdef INST_LOADER_CSUM_EN
            csum      <= '0;
`endif
        end else begin
            inst_wen <= 1'b0;
            // Write-port stage: the word completed this edge is written next cycle.
            if (word_valid) begin
                inst_wen  <= 1'b1;
                inst_addr <= word_cnt[ADDR_W-1:0];
                inst_data <= word;
                word_cnt  <= word_cnt + 1'b1;
            end

            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (bus.start) begin
                        state    <= S_LEN_LO;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        err      <= 1'b0;
                        word_cnt <= '0;
`ifdef INST_LOADER_CSUM_EN
                        csum     <= '0;
`endif
                    end
                end
                S_LEN_LO: begin
                    if (accept) begin
                        len_lo <= bus.in_byte;
                        state  <= S_LEN_HI;
                    end
                end
                S_LEN_HI: begin
                    if (accept) begin
                        len <= len_next;
                        if (len_next == 16'd0) begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else if (len_next > 16'(DEPTH)) begin
                            state <= S_ERR;
                            busy  <= 1'b0;
                            err   <= 1'b1;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (data_accept) begin
`ifdef INST_LOADER_CSUM_EN
                        csum <= csum + bus.in_byte;
                        if (word_valid && last_word) state <= S_CSUM;
`else
                        if (word_valid && last_word) state <= S_FLUSH;
`endif
                    end
                end
`ifdef INST_LOADER_CSUM_EN
                // The final write drains while the sum byte is awaited.
                S_CSUM: begin
                    if (accept) begin
                        busy <= 1'b0;
                        if (bus.in_byte == csum) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= S_ERR;
                            err   <= 1'b1;
                        end
                    end
                end
`endif
                S_FLUSH: begin
                    state <= S_DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.inst_wen  = inst_wen;
    assign bus.inst_addr = inst_addr;
    assign bus.inst_data = inst_data;
    assign bus.busy      = busy;
    assign bus.cpu_hold  = busy;
    assign bus.done      = done;
    assign bus.err       = err;
endmodule

// File: tb/tb_inst_loader.sv
// Randomized bench for inst_loader: frames are built from random words and the
// expected write list / completion status is derived from the frame rules.
module tb_inst_loader;
    import rv32i_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    inst_loader_if #(.ADDR_W(IMEM_ADDR_W)) bus ();

    inst_loader #(
        .ADDR_W (IMEM_ADDR_W),
        .DEPTH  (IMEM_DEPTH),
        .DATA_W (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [IMEM_ADDR_W-1:0] addr;
        logic [31:0]            data;
    } wr_t;
    wr_t wr_q[$];

    always @(negedge clk)
        if (bus.inst_wen === 1'b1)
            wr_q.push_back(wr_t'{addr: bus.inst_addr, data: bus.inst_data});

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // All driving tasks start and end at posedge+1.
    task automatic pulse_start();
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int c = 0;
        if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        bus.in_valid = 1'b1;
        bus.in_byte  = b;
        while (bus.in_ready !== 1'b1 && c < 50) begin
            @(posedge clk); #1;
            c++;
        end
        if (c >= 50) begin
            check("ready_timeout", 32'd0, 32'd1);
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic run_frame(input int n, input bit gaps, input bit fixed13,
                             input bit bad_csum, input bit poke_start);
        logic [31:0] words[$];
        logic [31:0] w;
        logic [15:0] len;
        logic [7:0]  sum;
        bit          legal, exp_done;
        int          c;
        len   = n[15:0];
        legal = (n <= IMEM_DEPTH);
        sum   = 8'd0;
`ifdef INST_LOADER_CSUM_EN
        exp_done = legal && !bad_csum;
`else
        exp_done = legal;
        if (bad_csum) exp_done = legal;
`endif
        wr_q.delete();
        pulse_start();
        send_byte(len[7:0], gaps);
        if (poke_start) pulse_start();
        send_byte(len[15:8], gaps);
        if (n == 0 || !legal) begin
            @(negedge clk);
            check("len_done", bus.done, legal);
            check("len_err", bus.err, !legal);
            check("len_busy", bus.busy, 0);
            check("len_ready", bus.in_ready, 0);
        end else begin
            for (int i = 0; i < n; i++) begin
                w = fixed13 ? 32'h0000_0013 : $urandom;
                words.push_back(w);
                for (int b = 0; b < 4; b++) begin
                    sum = sum + w[8*b +: 8];
                    send_byte(w[8*b +: 8], gaps);
                end
            end
`ifdef INST_LOADER_CSUM_EN
            send_byte(bad_csum ? sum + 8'd1 : sum, gaps);
`else
            @(negedge clk);
            check("last_wen", bus.inst_wen, 1);
            check("last_busy", bus.busy, 1);
            check("last_done_early", bus.done, 0);
`endif
            c = 0;
            @(negedge clk);
            while (!(bus.done || bus.err) && c < 20) begin
                @(negedge clk);
                c++;
            end
            check("end_done", bus.done, exp_done);
            check("end_err", bus.err, !exp_done);
            check("end_busy", bus.busy, 0);
            check("end_hold", bus.cpu_hold, 0);
            check("end_ready", bus.in_ready, 0);
        end
        @(negedge clk);
        check("n_writes", 32'(wr_q.size()), legal ? 32'(n) : 32'd0);
        for (int i = 0; i < wr_q.size() && i < words.size(); i++) begin
            check("wr_addr", 32'(wr_q[i].addr), 32'(i));
            check("wr_data", wr_q[i].data, words[i]);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_byte  = 8'h00;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check("rst_busy", bus.busy, 0);
        check("rst_hold", bus.cpu_hold, 0);
        check("rst_done", bus.done, 0);
        check("rst_err", bus.err, 0);
        check("rst_ready", bus.in_ready, 0);
        check("rst_wen", bus.inst_wen, 0);
        check("rst_addr", 32'(bus.inst_addr), 0);
        check("rst_data", bus.inst_data, 0);
        @(posedge clk); #1;

        // Abort mid-DATA after five bytes.
        pulse_start();
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        send_byte(8'hCC, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_busy", bus.busy, 0);
        check("abort_ready", bus.in_ready, 0);
        check("abort_done", bus.done, 0);
        check("abort_wen", bus.inst_wen, 0);
        check("abort_writes", 32'(wr_q.size()), 0);
        @(posedge clk); #1;

        run_frame(1, 0, 1, 0, 0);
        run_frame(1, 1, 1, 0, 1);
        run_frame(128, 0, 0, 0, 0);
        run_frame(129, 0, 0, 0, 0);
        run_frame(0, 1, 0, 0, 0);
        for (int k = 0; k < 6; k++)
            run_frame(int'($urandom_range(1, 8)), 1, 0, 0, k == 2);
`ifdef INST_LOADER_CSUM_EN
        run_frame(1, 0, 1, 1, 0);
        run_frame(3, 1, 0, 1, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
